// File: rtl/midi_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : midi_note_decoder
// Brief    : Parses a received MIDI byte stream into Note On/Off events
//            (note/note_ready) for the polyphony dispatcher. All other
//            message types are consumed and discarded.
// Config   : define MIDI_RUNNING_STATUS_EN to honour running status across
//            events; otherwise running status is dropped after each event.
// Revision : 1.0 - initial release
// ============================================================================

package MIDI;
  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_status_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   key;
    logic [6:0]   velocity;
  } note_change_t;
endpackage

module midi_note_decoder #(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic               clock_50_000_000,
  input  logic               reset,
  input  logic [7:0]         midi_byte,
  input  logic               midi_byte_ready,
  output MIDI::note_change_t note,
  output logic               note_ready,
  output logic               protocol_error
);

  localparam logic [3:0] CHAN = CHANNEL[3:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    WAIT_VEL = 2'd2,
    SKIP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         key_q, key_d;
  logic               rs_valid_q, rs_valid_d;
  MIDI::note_status_t rs_kind_q, rs_kind_d;
  MIDI::note_change_t note_q, note_d;
  logic               note_ready_q, note_ready_d;
  logic               perr_q, perr_d;

  logic is_realtime;
  logic is_note_status;
  logic chan_ok;
  logic mid_message;

  // Byte classification.
  assign is_realtime    = (midi_byte[7:3] == 5'b11111);
  assign is_note_status = (midi_byte[7:5] == 3'b100);
  assign chan_ok        = OMNI || (midi_byte[3:0] == CHAN);
  assign mid_message    = (state_q == WAIT_KEY) || (state_q == WAIT_VEL);

  // Next-state and event computation for one received byte.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    rs_valid_d   = rs_valid_q;
    rs_kind_d    = rs_kind_q;
    note_d       = note_q;
    note_ready_d = 1'b0;
    perr_d       = 1'b0;

    if (midi_byte_ready && !is_realtime) begin
      if (midi_byte[7]) begin
        // Any status byte aborts a partially received note message.
        perr_d = mid_message;
        if (is_note_status && chan_ok) begin
          rs_valid_d = 1'b1;
          rs_kind_d  = midi_byte[4] ? MIDI::NOTE_ON : MIDI::NOTE_OFF;
          state_d    = WAIT_KEY;
        end else begin
          rs_valid_d = 1'b0;
          state_d    = SKIP;
        end
      end else begin
        case (state_q)
          WAIT_KEY: begin
            key_d   = midi_byte[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            // Note On with zero velocity is reported as a Note Off.
            note_d.status   = ((rs_kind_q == MIDI::NOTE_ON) && (midi_byte[6:0] != 7'd0))
                              ? MIDI::NOTE_ON : MIDI::NOTE_OFF;
            note_d.key      = key_q;
            note_d.velocity = midi_byte[6:0];
            note_ready_d    = 1'b1;
            state_d         = IDLE;
`ifndef MIDI_RUNNING_STATUS_EN
            rs_valid_d      = 1'b0;
`endif
          end
          IDLE: begin
            // Without running status rs_valid_q is always clear here.
            if (rs_valid_q) begin
              key_d   = midi_byte[6:0];
              state_d = WAIT_VEL;
            end else begin
              perr_d  = 1'b1;
            end
          end
          default: begin
            // SKIP: data of a discarded message is dropped silently.
          end
        endcase
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state_q      <= IDLE;
      key_q        <= 7'd0;
      rs_valid_q   <= 1'b0;
      rs_kind_q    <= MIDI::NOTE_OFF;
      note_q       <= '0;
      note_ready_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      rs_valid_q   <= rs_valid_d;
      rs_kind_q    <= rs_kind_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
      perr_q       <= perr_d;
    end
  end

  assign note           = note_q;
  assign note_ready     = note_ready_q;
  assign protocol_error = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_note_decoder
// Brief    : Self-checking bench for midi_note_decoder (CHANNEL=0, OMNI=0).
// Revision : 1.0 - initial release
// ============================================================================

module tb_midi_note_decoder;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         midi_byte = 8'h00;
  logic               midi_byte_ready = 1'b0;
  MIDI::note_change_t note;
  logic               note_ready;
  logic               protocol_error;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [14:0] exp_q [$];
  logic [14:0] last_exp = '0;

  always #10 clk = ~clk;

  midi_note_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .clock_50_000_000 (clk),
    .reset            (reset),
    .midi_byte        (midi_byte),
    .midi_byte_ready  (midi_byte_ready),
    .note             (note),
    .note_ready       (note_ready),
    .protocol_error   (protocol_error)
  );

  typedef struct {
    string       name;
    int          n;
    logic [55:0] bytes;   // first byte in the top 8 bits
    int          nev;
    logic [14:0] e0;
    logic [14:0] e1;
    int          nerr;
  } vec_t;

  vec_t vecs [$];

  // Scoreboard: every note_ready pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset) begin
      if (protocol_error) err_seen++;
      if (note_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h required=none", note);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          if (note !== e) begin
            errors++;
            $display("FAIL event got=%h required=%h", note, e);
          end
        end
      end
    end
  end

  task automatic add(input string nm, input int n, input logic [55:0] b,
                     input int nev, input logic [14:0] e0, input logic [14:0] e1,
                     input int nerr);
    vec_t v;
    v.name = nm; v.n = n; v.bytes = b; v.nev = nev; v.e0 = e0; v.e1 = e1; v.nerr = nerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  // Called at a falling edge; the byte is captured by the next rising edge.
  task automatic send(input logic [7:0] b);
    midi_byte       = b;
    midi_byte_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    midi_byte_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_note", 32'(note), 32'd0);
    check("reset_ready", 32'(note_ready), 32'd0);
    check("reset_perr", 32'(protocol_error), 32'd0);
    exp_q.delete();
    err_seen = 0;
    last_exp = '0;
  endtask

  initial begin
    // name, nbytes, bytes, nevents, ev0, ev1, nerr
    add("note_on",   3, 56'h903C40_00000000, 1, {1'b1, 7'd60, 7'd64},  '0, 0);
    add("note_off",  3, 56'h803C7B_00000000, 1, {1'b0, 7'd60, 7'd123}, '0, 0);
`ifdef MIDI_RUNNING_STATUS_EN
    add("running",   5, 56'h900A141428_0000, 2, {1'b1, 7'd10, 7'd20}, {1'b1, 7'd20, 7'd40}, 0);
`else
    add("running",   5, 56'h900A141428_0000, 1, {1'b1, 7'd10, 7'd20}, '0, 2);
`endif
    add("vel_zero",  3, 56'h901E00_00000000, 1, {1'b0, 7'd30, 7'd0},  '0, 0);
    add("realtime",  5, 56'h90F828FE50_0000, 1, {1'b1, 7'd40, 7'd80}, '0, 0);
    add("chan1",     3, 56'h910A14_00000000, 0, '0, '0, 0);
    add("chan9",     3, 56'h993C40_00000000, 0, '0, '0, 0);
    add("chan15",    3, 56'h9F1020_00000000, 0, '0, '0, 0);
    add("abort",     3, 56'h900AB0_00000000, 0, '0, '0, 1);
    add("no_status", 2, 56'h1415_0000000000, 0, '0, '0, 2);
    add("sysex",     7, 56'hF00102F7900102,  1, {1'b1, 7'd1, 7'd2},   '0, 0);
    add("max_vals",  3, 56'h807F7F_00000000, 1, {1'b0, 7'd127, 7'd127}, '0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      if (vecs[i].nev > 0) exp_q.push_back(vecs[i].e0);
      if (vecs[i].nev > 1) exp_q.push_back(vecs[i].e1);
      last_exp = (vecs[i].nev > 1) ? vecs[i].e1 : vecs[i].e0;
      for (int k = 0; k < vecs[i].n; k++) send(vecs[i].bytes[55 - 8*k -: 8]);
      midi_byte_ready = 1'b0;
      repeat (4) @(negedge clk);
      check({vecs[i].name, "_pending"}, 32'(exp_q.size()), 32'd0);
      check({vecs[i].name, "_perr"}, 32'(err_seen), 32'(vecs[i].nerr));
      check({vecs[i].name, "_hold"}, 32'(note),
            (vecs[i].nev > 0) ? 32'(last_exp) : 32'd0);
    end

    // Latency: note_ready exactly one clock after the velocity strobe, single cycle.
    do_reset();
    exp_q.push_back({1'b1, 7'd60, 7'd64});
    send(8'h90); send(8'h3C);
    check("lat_before", 32'(note_ready), 32'd0);
    send(8'h40);
    midi_byte_ready = 1'b0;
    check("lat_ready", 32'(note_ready), 32'd1);
    check("lat_note", 32'(note), 32'({1'b1, 7'd60, 7'd64}));
    @(negedge clk);
    check("lat_pulse_end", 32'(note_ready), 32'd0);

    // Reset between key and velocity: partial message and running status dropped.
    do_reset();
    send(8'h90); send(8'h3C);
    midi_byte_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h40);
    midi_byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_pending", 32'(exp_q.size()), 32'd0);
    check("rst_mid_note", 32'(note), 32'd0);
    check("rst_mid_perr", 32'(err_seen), 32'd1);

    // Spaced strobes with idle cycles between bytes.
    do_reset();
    exp_q.push_back({1'b0, 7'd5, 7'd9});
    send(8'h80); midi_byte_ready = 1'b0; repeat (3) @(negedge clk);
    send(8'h05); midi_byte_ready = 1'b0; repeat (3) @(negedge clk);
    send(8'h09); midi_byte_ready = 1'b0; repeat (3) @(negedge clk);
    check("spaced_pending", 32'(exp_q.size()), 32'd0);
    check("spaced_note", 32'(note), 32'({1'b0, 7'd5, 7'd9}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
